// File: rtl/argmax_feeder.sv
// argmax_feeder: transmit side of the four-lane argmax compare interface.
//
// Holds up to DEPTH signed 16-bit layer outputs. On start it clears the
// comparator, streams the buffer four entries per trigger (trigger cycle
// followed by a hold cycle in which the comparator samples the lanes),
// then captures the 1-based argmax index reported by the comparator and
// presents it together with a one-cycle done pulse.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data  buffer write port (accepted only in IDLE, addr < DEPTH)
//   wr_err              one-cycle pulse after a dropped write
//   start, num_values   begin a pass over entries 0..num_values-1 (clamped to DEPTH)
//   busy, done          pass in progress / result_index valid pulse
//   result_index        captured argmax index, 1-based, 0 = none
//   cmp_reset/enable/trig, cmp_in1..4   comparator control and lanes
//   cmp_index           comparator running argmax index
module argmax_feeder #(
    parameter int DEPTH  = 40,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    output logic              wr_err,
    input  logic              start,
    input  logic [ADDR_W:0]   num_values,
    output logic              busy,
    output logic              done,
    output logic [7:0]        result_index,
    output logic              cmp_reset,
    output logic              cmp_enable,
    output logic              cmp_trig,
    output logic [15:0]       cmp_in1,
    output logic [15:0]       cmp_in2,
    output logic [15:0]       cmp_in3,
    output logic [15:0]       cmp_in4,
    input  logic [7:0]        cmp_index
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_TRIG = 3'd2,
        S_HOLD = 3'd3,
        S_WAIT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    // Most negative value: the comparator's strict > test never picks it.
    localparam logic [15:0]     PAD     = 16'h8000;

    state_t            state_r;
    state_t            state_next_s;
    logic [15:0]       mem_r [0:DEPTH-1];
    logic [ADDR_W:0]   n_r;
    logic [ADDR_W:0]   groups_r;
    logic [ADDR_W:0]   grp_r;
    logic [ADDR_W:0]   n_start_s;
    logic [ADDR_W:0]   groups_start_s;
    logic              load_s;
    logic [ADDR_W:0]   load_grp_s;
    logic [ADDR_W:0]   base_s;
    logic [ADDR_W:0]   lane_addr_s [4];
    logic [15:0]       lane_val_s  [4];
    logic [15:0]       lane_r      [4];
    logic              wr_ok_s;
    logic              busy_r;
    logic              done_r;
    logic              wr_err_r;
    logic              cmp_enable_r;
    logic              cmp_trig_r;
    logic [7:0]        result_index_r;

    assign n_start_s      = (num_values > DEPTH_W) ? DEPTH_W : num_values;
    assign groups_start_s = (n_start_s + (ADDR_W+1)'(3)) >> 2;
    assign wr_ok_s        = wr_en && (state_r == S_IDLE) && ({1'b0, wr_addr} < DEPTH_W);

    // Next-state logic and group-load control
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        load_grp_s   = grp_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_CLR;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CLR: begin
                if (groups_r != '0) begin
                    state_next_s = S_TRIG;
                    load_s       = 1'b1;
                    load_grp_s   = '0;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_TRIG: state_next_s = S_HOLD;
            S_HOLD: begin
                // (grp + 1) < G avoids the G-1 underflow form
                if ((grp_r + (ADDR_W+1)'(1)) < groups_r) begin
                    state_next_s = S_TRIG;
                    load_s       = 1'b1;
                    load_grp_s   = grp_r + (ADDR_W+1)'(1);
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_WAIT:  state_next_s = S_DONE;
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Lane values for the group about to be loaded; entries past N are padded
    assign base_s = {load_grp_s[ADDR_W-2:0], 2'b00};
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr_s[k] = base_s + (ADDR_W+1)'(k);
            if (lane_addr_s[k] < n_r) begin
                lane_val_s[k] = mem_r[lane_addr_s[k][ADDR_W-1:0]];
            end else begin
                lane_val_s[k] = PAD;
            end
        end
    end

    // Buffer storage; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // State register, pass bookkeeping and registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_IDLE;
            n_r            <= '0;
            groups_r       <= '0;
            grp_r          <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            wr_err_r       <= 1'b0;
            cmp_enable_r   <= 1'b0;
            cmp_trig_r     <= 1'b0;
            result_index_r <= 8'd0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == S_IDLE) && start) begin
                n_r      <= n_start_s;
                groups_r <= groups_start_s;
                grp_r    <= '0;
            end else if (load_s) begin
                grp_r <= load_grp_s;
            end
            busy_r       <= (state_next_s != S_IDLE);
            done_r       <= (state_next_s == S_DONE);
            cmp_trig_r   <= (state_next_s == S_TRIG);
            cmp_enable_r <= (state_next_s == S_TRIG) || (state_next_s == S_HOLD) ||
                            (state_next_s == S_WAIT);
            wr_err_r     <= wr_en && !wr_ok_s;
            // Comparator index has settled by the WAIT cycle
            if (state_r == S_WAIT) begin
                result_index_r <= cmp_index;
            end
        end
    end

    // Lane registers: load on entry to TRIG, hold through HOLD, pad in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) lane_r[k] <= PAD;
        end else if (load_s) begin
            for (int k = 0; k < 4; k++) lane_r[k] <= lane_val_s[k];
        end else if (state_next_s == S_IDLE) begin
            for (int k = 0; k < 4; k++) lane_r[k] <= PAD;
        end
    end

    // Comparator reset follows the block reset directly so any reset clears it
    assign cmp_reset    = reset | (state_r == S_CLR);
    assign busy         = busy_r;
    assign done         = done_r;
    assign wr_err       = wr_err_r;
    assign cmp_enable   = cmp_enable_r;
    assign cmp_trig     = cmp_trig_r;
    assign result_index = result_index_r;
    assign cmp_in1      = lane_r[0];
    assign cmp_in2      = lane_r[1];
    assign cmp_in3      = lane_r[2];
    assign cmp_in4      = lane_r[3];

endmodule

// File: tb/tb_argmax_feeder.sv
// Self-checking bench for argmax_feeder: a behavioural comparator model
// drives cmp_index, and a plain argmax over a shadow buffer gives the
// expected result for each pass.
module tb_argmax_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_err;
    logic        start;
    logic [6:0]  num_values;
    logic        busy, done;
    logic [7:0]  result_index;
    logic        cmp_reset, cmp_enable, cmp_trig;
    logic [15:0] cmp_in1, cmp_in2, cmp_in3, cmp_in4;
    logic [7:0]  cmp_index;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] shadow [40];

    argmax_feeder dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
        .start(start), .num_values(num_values),
        .busy(busy), .done(done), .result_index(result_index),
        .cmp_reset(cmp_reset), .cmp_enable(cmp_enable), .cmp_trig(cmp_trig),
        .cmp_in1(cmp_in1), .cmp_in2(cmp_in2), .cmp_in3(cmp_in3), .cmp_in4(cmp_in4),
        .cmp_index(cmp_index)
    );

    always #5 clk = ~clk;

    // Comparator model: samples the lanes one cycle after an enabled trigger,
    // strict greater-than, earliest lane wins within a group.
    logic signed [15:0] m_best;
    logic [7:0]         m_idx;
    logic [7:0]         m_grp;
    logic               m_trig_d;

    function automatic logic [23:0] cmp_step(input logic signed [15:0] best, input logic [7:0] idx,
                                             input logic [7:0] grp, input logic [0:3][15:0] l);
        logic signed [15:0] b;
        logic [7:0]         i;
        b = best;
        i = idx;
        for (int k = 0; k < 4; k++) begin
            if ($signed(l[k]) > b) begin
                b = l[k];
                i = 8'(grp * 4 + k + 1);
            end
        end
        return {b, i};
    endfunction

    always @(posedge clk) begin
        if (cmp_reset) begin
            m_best   <= 16'sh8000;
            m_idx    <= 8'd0;
            m_grp    <= 8'd0;
            m_trig_d <= 1'b0;
        end else begin
            m_trig_d <= cmp_trig & cmp_enable;
            if (cmp_enable && m_trig_d) begin
                {m_best, m_idx} <= cmp_step(m_best, m_idx, m_grp, {cmp_in1, cmp_in2, cmp_in3, cmp_in4});
                m_grp <= m_grp + 8'd1;
            end
        end
    end
    assign cmp_index = m_idx;

    // Reference: first position of the strict maximum over min(nv,40) entries.
    function automatic int ref_argmax(input int nv);
        int n, idx;
        int best;
        n = (nv > 40) ? 40 : nv;
        best = -32768;
        idx = 0;
        for (int i = 0; i < n; i++) begin
            if (int'($signed(shadow[i])) > best) begin
                best = int'($signed(shadow[i]));
                idx = i + 1;
            end
        end
        return idx;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the next negedge.
    task automatic write_entry(input int a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a < 40) shadow[a] = d;
    endtask

    task automatic run_pass(input logic [6:0] nv, input logic we, input logic [5:0] wa,
                            input logic [15:0] wd, output int lat, output int trigs,
                            output int clrs, output int gap_bad, output int busy_bad,
                            output logic [7:0] idx, output logic [0:3][15:0] lanes);
        int prev_k;
        lat = -1; trigs = 0; clrs = 0; gap_bad = 0; busy_bad = 0; idx = 8'hFF;
        lanes = '0; prev_k = 0;
        start = 1'b1; num_values = nv; wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        for (int k = 1; k <= 300 && lat < 0; k++) begin
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0;
            if (cmp_trig) begin
                trigs++;
                if (prev_k != 0 && k - prev_k != 2) gap_bad++;
                prev_k = k;
                lanes = {cmp_in1, cmp_in2, cmp_in3, cmp_in4};
            end
            if (cmp_reset) clrs++;
            if (!busy) busy_bad++;
            if (done) begin
                lat = k;
                idx = result_index;
            end
        end
        if (we && wa < 6'd40) shadow[wa] = wd;
    endtask

    task automatic verify_pass(input string nm, input logic [6:0] nv, input logic we,
                               input logic [5:0] wa, input logic [15:0] wd,
                               input int e_idx, input int e_trigs, input int e_lat,
                               input bit chk_l, input logic [0:3][15:0] e_lanes);
        int lat, trigs, clrs, gap_bad, busy_bad;
        logic [7:0] idx;
        logic [0:3][15:0] lanes;
        run_pass(nv, we, wa, wd, lat, trigs, clrs, gap_bad, busy_bad, idx, lanes);
        check({nm, " latency"}, lat, e_lat);
        check({nm, " result_index"}, idx, e_idx);
        check({nm, " trig count"}, trigs, e_trigs);
        check({nm, " trig spacing"}, gap_bad, 0);
        check({nm, " cmp_reset cycles"}, clrs, 1);
        check({nm, " busy low in pass"}, busy_bad, 0);
        if (chk_l) check({nm, " last lanes"}, lanes, e_lanes);
        @(negedge clk);
        check({nm, " done one cycle"}, done, 0);
        check({nm, " idle after done"}, busy, 0);
        check({nm, " lanes padded idle"}, cmp_in1, 16'h8000);
    endtask

    typedef struct packed {
        logic             fill_all;
        logic [6:0]       nv;
        logic [0:7][15:0] vals;
        logic [7:0]       exp_idx;
        logic [7:0]       exp_trigs;
        logic [7:0]       exp_lat;
        logic             chk_lanes;
        logic [0:3][15:0] exp_lanes;
    } vec_t;

    vec_t tv [5];

    initial begin
        forever begin
            #2000000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1);
        end
    end

    initial begin
        int lat, trigs, clrs, gap_bad, busy_bad, got, seen, nv, n, g;
        logic [7:0] idx;
        logic [0:3][15:0] lanes;
        logic [15:0] d;

        tv[0] = '{1'b0, 7'd8, {16'd5, 16'd9, 16'hFFFD, 16'd2, 16'd7, 16'd1, 16'd0, 16'd4},
                  8'd2, 8'd2, 8'd7, 1'b0, 64'd0};
        tv[1] = '{1'b0, 7'd6, {16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                  8'd6, 8'd2, 8'd7, 1'b1, {16'h0001, 16'h7FFF, 16'h8000, 16'h8000}};
        tv[2] = '{1'b0, 7'd0, {16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3},
                  8'd0, 8'd0, 8'd3, 1'b0, 64'd0};
        tv[3] = '{1'b1, 7'd60, {16'd100, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                  8'd1, 8'd10, 8'd23, 1'b0, 64'd0};
        tv[4] = '{1'b1, 7'd40, {16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                  8'd0, 8'd10, 8'd23, 1'b0, 64'd0};

        reset = 1'b1; wr_en = 1'b0; wr_addr = 6'd0; wr_data = 16'd0;
        start = 1'b0; num_values = 7'd0;
        repeat (3) @(negedge clk);
        check("reset cmp_reset", cmp_reset, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset cmp_trig", cmp_trig, 0);
        check("reset cmp_enable", cmp_enable, 0);
        check("reset result_index", result_index, 0);
        check("reset cmp_in1", cmp_in1, 16'h8000);
        check("reset cmp_in4", cmp_in4, 16'h8000);
        reset = 1'b0;
        @(negedge clk);
        check("idle cmp_reset", cmp_reset, 0);

        // Table-driven passes
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < (tv[i].fill_all ? 40 : 8); j++)
                write_entry(j, tv[i].fill_all ? tv[i].vals[0] : tv[i].vals[j]);
            verify_pass($sformatf("vec%0d", i), tv[i].nv, 1'b0, 6'd0, 16'd0,
                        tv[i].exp_idx, tv[i].exp_trigs, tv[i].exp_lat,
                        tv[i].chk_lanes, tv[i].exp_lanes);
        end

        // Reset during the third trigger of a ten-group pass
        for (int j = 0; j < 40; j++) write_entry(j, 16'($urandom_range(0, 200)));
        start = 1'b1; num_values = 7'd40;
        @(posedge clk);
        seen = 0;
        for (int k = 0; k < 60 && seen < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (cmp_trig) seen++;
        end
        check("midreset reached 3rd trig", seen, 3);
        reset = 1'b1;
        #1;
        check("midreset cmp_reset during reset", cmp_reset, 1);
        @(negedge clk);
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset result_index", result_index, 0);
        check("midreset cmp_trig", cmp_trig, 0);
        reset = 1'b0;
        got = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) got++;
        end
        check("midreset no done", got, 0);
        verify_pass("after reset", 7'd40, 1'b0, 6'd0, 16'd0, ref_argmax(40), 10, 23, 1'b0, 64'd0);

        // Dropped writes: while busy, and out of range in IDLE
        for (int j = 0; j < 40; j++) write_entry(j, 16'(j * 3));
        start = 1'b1; num_values = 7'd40;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 16'h7FFF;
        @(negedge clk);
        wr_en = 1'b0;
        check("busy write wr_err", wr_err, 1);
        got = 0;
        for (int k = 0; k < 100 && got == 0; k++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        check("busy write pass completes", got, 1);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 6'd45; wr_data = 16'h7FFF;
        @(negedge clk);
        wr_en = 1'b0;
        check("addr 45 wr_err", wr_err, 1);
        write_entry(10, 16'd5);
        check("valid write no wr_err", wr_err, 0);
        verify_pass("buffer unchanged", 7'd40, 1'b0, 6'd0, 16'd0, ref_argmax(40), 10, 23, 1'b0, 64'd0);

        // start and write in the same IDLE cycle: the pass sees the new value
        verify_pass("start+write", 7'd8, 1'b1, 6'd7, 16'h7FFF, 8, 2, 7, 1'b0, 64'd0);

        // Randomized passes with frequent ties and padding-valued entries
        for (int r = 0; r < 20; r++) begin
            for (int j = 0; j < 40; j++) begin
                if ($urandom_range(0, 7) == 0) d = 16'h8000;
                else d = 16'($urandom_range(0, 20)) - 16'd10;
                write_entry(j, d);
            end
            nv = $urandom_range(0, 63);
            n = (nv > 40) ? 40 : nv;
            g = (n + 3) / 4;
            verify_pass($sformatf("rand%0d nv=%0d", r, nv), 7'(nv), 1'b0, 6'd0, 16'd0,
                        ref_argmax(nv), g, 2 * g + 3, 1'b0, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
